// File: rtl/char_buf.sv
// Character/attribute buffer for a 128x32 text display: single-port RAM that is
// swept to a blank-cell word after every reset before normal access is allowed.
module char_buf #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter logic [DATA_W-1:0] CLEAR_WORD = 32'hFFF0_0020
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic [DATA_W-1:0]   dataout_q;

  // No reset on the array so it maps onto block RAM.
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  // One shared write port: the sweep owns it in CLEAR, the user in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr;
    mem_wdata = datain;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_ptr_q;
      mem_wdata = CLEAR_WORD;
    end else begin
      mem_we    = we;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      dataout_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          dataout_q <= '0;
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == {ADDR_W{1'b1}}) begin
            state_q <= RUN;
          end
        end
        default: begin
          // Write-first: a written word is returned on the same edge.
          if (we) begin
            dataout_q <= datain;
          end else begin
            dataout_q <= mem[addr];
          end
        end
      endcase
    end
  end

  assign busy    = (state_q == CLEAR);
  assign dataout = dataout_q;

endmodule

// File: tb/tb_char_buf.sv
// Directed bench for char_buf: sweep timing, write-first reads, dropped writes
// during the sweep, and asynchronous reset in both states.
module tb_char_buf;

  localparam logic [31:0] CW = 32'hFFF0_0020;

  logic        clock;
  logic        reset;
  logic [11:0] addr;
  logic        we;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int n_cyc;

  char_buf dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .datain  (datain),
    .dataout (dataout),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Counts edges until busy drops (bounded); optionally plants a write at
  // cycle inject_at and stops early at cycle abort_at.
  task automatic count_sweep(input int inject_at, input int abort_at, output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(posedge clock);
      #1;
      n++;
      if (n == inject_at) begin
        we = 1'b1; addr = 12'd5; datain = 32'hDEAD_BEEF;
      end else begin
        we = 1'b0;
      end
      if (n == abort_at) break;
    end
    we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    addr = a; we = 1'b0;
    @(posedge clock);
    #1;
    check(tag, dataout, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    addr = a; we = 1'b1; datain = d;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; addr = '0; datain = '0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_dataout", dataout, 32'd0);
    #10 reset = 1'b1;   // released off-edge at t=22

    // Partial sweep, then async reset mid-sweep at cycle 2000.
    count_sweep(0, 2000, n_cyc);
    check("partial_cycles", n_cyc, 32'd2000);
    check("mid_sweep_busy", {31'd0, busy}, 32'd1);
    check("mid_sweep_dataout", dataout, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_dataout", dataout, 32'd0);
    #2 reset = 1'b1;

    // Full sweep with a write attempt at cycle 10 that must be dropped.
    count_sweep(10, 0, n_cyc);
    check("sweep1_cycles", n_cyc, 32'd4096);
    check("after_sweep_busy", {31'd0, busy}, 32'd0);

    rd(12'd0,    CW, "clr_addr0");
    rd(12'd2048, CW, "clr_addr2048");
    rd(12'd4095, CW, "clr_addr4095");
    rd(12'd5,    CW, "dropped_write_addr5");

    wr(12'h0A3, 32'h0F00_0041);
    check("wr_first_0A3", dataout, 32'h0F00_0041);
    rd(12'h0A4, CW, "neighbour_0A4");
    rd(12'h0A3, 32'h0F00_0041, "readback_0A3");

    wr(12'hFFF, 32'h1234_5678);
    check("wr_first_FFF", dataout, 32'h1234_5678);
    rd(12'h000, CW, "no_alias_000");
    rd(12'hFFF, 32'h1234_5678, "readback_FFF");
    rd(12'h7FF, CW, "no_alias_7FF");

    wr(12'd1, 32'hA1A1_0001);
    wr(12'd2, 32'hB2B2_0002);
    wr(12'd3, 32'hC3C3_0003);
    rd(12'd1, 32'hA1A1_0001, "b2b_addr1");
    rd(12'd2, 32'hB2B2_0002, "b2b_addr2");
    rd(12'd3, 32'hC3C3_0003, "b2b_addr3");

    // Async reset while in RUN with non-zero dataout.
    #2 reset = 1'b0;
    #1;
    check("run_reset_busy", {31'd0, busy}, 32'd1);
    check("run_reset_dataout", dataout, 32'd0);
    #2 reset = 1'b1;

    count_sweep(0, 0, n_cyc);
    check("sweep2_cycles", n_cyc, 32'd4096);
    rd(12'h0A3, CW, "resweep_0A3");
    rd(12'd2,   CW, "resweep_addr2");
    rd(12'hFFF, CW, "resweep_FFF");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
